// File: rtl/transmit.sv
// transmit: buffered UART transmitter.
//   Bytes enter a 2^L-entry FIFO over a valid/ready handshake and are sent on
//   o_txd as start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parameters:
//   D      - clock cycles per serial bit (>= 2)
//   L      - log2 of FIFO depth (>= 1)
//   PARITY - 0: 8N1 frames, 1: even-parity bit after the data bits
// Ports:
//   i_clk   - rising-edge clock
//   i_rst   - asynchronous active-low reset
//   i_data  - byte to send, taken when i_valid && o_ready
//   i_valid - i_data valid this cycle
//   o_ready - FIFO not full (from the registered count only)
//   o_txd   - registered serial line, idles high
//   o_busy  - registered, high whenever a frame is in progress
//   o_count - registered FIFO occupancy, 0..2^L
module transmit #(
  parameter int D      = 5,
  parameter int L      = 2,
  parameter int PARITY = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_txd,
  output logic       o_busy,
  output logic [L:0] o_count
);

  localparam int            TW     = (D > 1) ? $clog2(D) : 1;
  localparam int            DEPTH  = 1 << L;
  localparam logic [TW-1:0] T_LAST = TW'(D - 1);
  localparam logic [L:0]    FULL   = (L + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          txd_d;
  logic          load;
  logic          push;
  logic          last;

  logic [7:0]    mem [DEPTH];
  logic [L-1:0]  wr_ptr, rd_ptr;

  // ---------------- FIFO ----------------
  assign o_ready = (o_count != FULL);
  assign push    = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      o_txd   <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      o_txd   <= txd_d;
      o_busy  <= (state_d != S_IDLE);
    end
  end

  // ---------------- FSM: next state ----------------
  assign last = (timer_q == T_LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (o_count != '0) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (last) begin
          if (bit_q == 3'd7) state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_PAR: begin
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        // A queued byte starts its start bit straight after the stop bit.
        if (last) begin
          if (o_count != '0) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || last) timer_d = '0;
    else                           timer_d = timer_q + 1'b1;

    byte_d = load ? mem[rd_ptr] : byte_q;
  end

  // ---------------- FSM: outputs ----------------
  // Line level is decoded from the upcoming state so o_txd can be registered
  // without a cycle of extra latency.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = byte_d[bit_d];
      S_PAR:   txd_d = ^byte_d;
      S_STOP:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_transmit.sv
module tb_transmit;

  localparam int D     = 5;
  localparam int L     = 2;
  localparam int DEPTH = 1 << L;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic [1:0] rdy, txd, busy;
  logic [L:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int bcnt [2] = '{0, 0};

  always #5 clk = ~clk;

  transmit #(.D(D), .L(L), .PARITY(0)) u_tx0 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(rdy[0]), .o_txd(txd[0]), .o_busy(busy[0]), .o_count(cnt0)
  );

  transmit #(.D(D), .L(L), .PARITY(1)) u_tx1 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(rdy[1]), .o_txd(txd[1]), .o_busy(busy[1]), .o_count(cnt1)
  );

  // ---------------- reference model ----------------
  // Each instance: a byte queue plus "frame in flight since cycle s". The line
  // level is derived from the frame layout: bit j = (cycle - s) / D.
  int         cyc = 0;
  int         m_cnt   [2] = '{0, 0};
  int         m_head  [2] = '{0, 0};
  bit         m_act   [2] = '{0, 0};
  int         m_start [2] = '{0, 0};
  logic [7:0] m_byte  [2];
  logic [7:0] m_mem   [2][DEPTH];

  function automatic int frame_len(input int p);
    return ((p != 0) ? 11 : 10) * D;
  endfunction

  function automatic logic exp_txd(input int p);
    int j;
    if (!m_act[p]) return 1'b1;
    j = (cyc - m_start[p]) / D;
    if (j == 0) return 1'b0;
    if (j <= 8) return m_byte[p][j-1];
    if (j == 9 && p != 0) return ^m_byte[p];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        m_cnt[p]  = 0;
        m_head[p] = 0;
        m_act[p]  = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int p = 0; p < 2; p++) begin
        bit do_push;
        bit do_pop;
        do_push = valid && (m_cnt[p] < DEPTH);
        do_pop  = 0;
        if (!m_act[p]) do_pop = (m_cnt[p] > 0);
        else if (cyc - m_start[p] == frame_len(p)) begin
          do_pop = (m_cnt[p] > 0);
          if (!do_pop) m_act[p] = 0;
        end
        if (do_pop) begin
          m_byte[p]  = m_mem[p][m_head[p]];
          m_head[p]  = (m_head[p] + 1) % DEPTH;
          m_cnt[p]   = m_cnt[p] - 1;
          m_act[p]   = 1;
          m_start[p] = cyc;
        end
        if (do_push) begin
          m_mem[p][(m_head[p] + m_cnt[p]) % DEPTH] = data;
          m_cnt[p] = m_cnt[p] + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge, then compare every output at the falling edge.
  task automatic tick();
    int c [2];
    @(negedge clk);
    c[0] = int'(cnt0);
    c[1] = int'(cnt1);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("txd%0d", p),   int'(txd[p]),  int'(exp_txd(p)));
      check($sformatf("busy%0d", p),  int'(busy[p]), int'(m_act[p]));
      check($sformatf("count%0d", p), c[p],          m_cnt[p]);
      check($sformatf("ready%0d", p), int'(rdy[p]),  (m_cnt[p] < DEPTH) ? 1 : 0);
      if (busy[p]) bcnt[p]++;
    end
  endtask

  task automatic push(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget; i++) begin
      idle = (busy == 2'b00) && (cnt0 == '0) && (cnt1 == '0);
      if (idle) break;
      tick();
    end
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  task automatic parity_probe(input logic [7:0] b, input int exp_bit);
    push(b);
    repeat (9 * D + 2) tick();
    check("parity_bit", int'(txd[1]), exp_bit);
    wait_idle(200);
  endtask

  int b0, b1;

  initial begin
    // Reset values
    repeat (3) tick();
    rst = 1'b1;
    repeat (20) tick();

    // Single byte, busy length per frame format
    b0 = bcnt[0]; b1 = bcnt[1];
    push(8'h55);
    wait_idle(200);
    check("busy_len0_single", bcnt[0] - b0, 10 * D);
    check("busy_len1_single", bcnt[1] - b1, 11 * D);

    // Parity bit values
    b1 = bcnt[1];
    parity_probe(8'h07, 1);
    check("busy_len1_par", bcnt[1] - b1, 11 * D);
    parity_probe(8'h03, 0);

    // Full FIFO while a frame is in flight
    push(8'h5A);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data  = 8'hA1 + 8'(i);
      tick();
    end
    valid = 1'b0;
    check("full_count", int'(cnt0), DEPTH);
    check("full_ready", int'(rdy[0]), 0);
    wait_idle(800);

    // Back-to-back frames
    b0 = bcnt[0]; b1 = bcnt[1];
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_idle(400);
    check("busy_len0_b2b", bcnt[0] - b0, 30 * D);
    check("busy_len1_b2b", bcnt[1] - b1, 33 * D);

    // Reset during data bit 3 with two bytes queued
    push(8'h0F);
    push(8'hAA);
    push(8'hBB);
    repeat (4 * D + 1) tick();
    #2 rst = 1'b0;
    #1;
    check("async_txd0", int'(txd[0]), 1);
    check("async_txd1", int'(txd[1]), 1);
    check("async_cnt0", int'(cnt0), 0);
    check("async_busy0", int'(busy[0]), 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (60) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 2) == 0);
      data  = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/transmit.md
# transmit

Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises each one onto `o_txd` as a start bit, 8 data bits LSB first, an optional even-parity bit and one stop bit. It is the sending end for the `receive` block. `D` and `PARITY` must match the paired receiver so that `transmit` → `receive` loopback benches work unchanged.

## Interface
- `D`, default 5: clock cycles per serial bit; legal range ≥ 2.
- `L`, default 2: log2 of FIFO depth; depth = 2^L entries; legal range ≥ 1.
- `PARITY`, default 0: 0 gives 8N1 frames (10 bits); 1 inserts an even-parity bit after data (11 bits).
- `i_clk`, input, 1: the single clock; all logic is on the rising edge.
- `i_rst`, input, 1: asynchronous, active-low reset.
- `i_data`, input, 8: byte to send; sampled when `i_valid && o_ready`.
- `i_valid`, input, 1: `i_data` is valid this cycle.
- `o_ready`, output, 1: FIFO not full. Combinational from the registered count; does not depend on `i_valid`.
- `o_txd`, output, 1: serial line, registered. Idle level is 1.
- `o_busy`, output, 1: registered; 1 whenever the state is not IDLE.
- `o_count`, output, L+1: registered FIFO occupancy, 0..2^L.

## Operation
- **Reset.** While `i_rst` = 0:
  - `o_txd` = 1, `o_busy` = 0, `o_count` = 0, `o_ready` = 1.
  - FSM is in IDLE; bit timer, bit index and FIFO pointers are 0.
  - Assertion mid-frame aborts the frame immediately. The partial frame and all buffered bytes are discarded.
- **FIFO.**
  - Push on `i_valid && o_ready`.
  - Pop only when the FSM loads a byte.
  - Simultaneous push and pop leaves `o_count` unchanged and both operations take effect.
  - When full, `o_ready` = 0 and `i_valid` is ignored with no overwrite.
  - Pointers are L bits wide and wrap modulo 2^L.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START when `o_count` ≠ 0. On that edge: pop the head into the shift register, clear the timer, drive `o_txd` = 0.
  - START → DATA after D cycles. Drive bit 0.
  - DATA: each bit is held D cycles; bits 0..7 go out LSB first. After bit 7, go to PAR if `PARITY` = 1, otherwise STOP.
  - PAR: drive the XOR of the 8 loaded bits for D cycles, then go to STOP.
  - STOP: drive 1 for D cycles. At the final cycle:
    - if `o_count` ≠ 0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Bit timer.** Counts 0..D−1; it advances state at D−1 and is cleared on every bit boundary.
- **Byte capture.** The loaded byte is held in a local shift register. A FIFO write during a frame never alters that frame.

## Timing
- Let the accepting edge be k (`i_valid && o_ready` sampled at k).
  - `o_count` increments after k.
  - If the FSM was IDLE, it pops at edge k+1, so `o_txd` falls after k+1 and `o_busy` rises after k+1.
- Frame duration is exactly 10·D cycles (PARITY = 0) or 11·D cycles (PARITY = 1), measured from the falling edge of `o_txd`.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle. There is no idle cycle.
- `o_busy` falls on the edge that returns the FSM to IDLE, i.e. exactly one frame length after its rise for a single byte.
- `o_count` decrements on the pop edge. `o_ready` follows `o_count` in the same cycle.

## Test plan
- **Reset values.** Hold `i_rst` = 0 for 3 cycles, release, idle 20 cycles → `o_txd` = 1, `o_busy` = 0, `o_count` = 0, `o_ready` = 1 throughout.
- **Single byte.** D = 5, PARITY = 0, push 0x55 at edge k → `o_txd` low from edge k+1 for 5 cycles, then data 1,0,1,0,1,0,1,0 at 5 cycles each, then 1 for 5 cycles. `o_busy` is high for exactly 50 cycles. Loopback `receive` outputs `o_data` = 0x55 with `o_error` = 0.
- **Parity.** PARITY = 1, push 0x07 → parity bit = 1 and the frame is 55 cycles. Push 0x03 → parity bit = 0.
- **Full FIFO.** L = 2 with FSM busy: push 0xA1..0xA5 on consecutive cycles. Depth is 4 and one byte is already popped into the shifter, so `o_count` reaches 4 and `o_ready` = 0 while 0xA5 is offered and is not accepted. `o_ready` returns 1 on the next pop edge.
- **Back-to-back order.** Push 0x00, 0xFF, 0x3C → three frames with no idle gap, in that order; total `o_busy` high time = 150 cycles.
- **Reset mid-frame.** Assert reset during DATA bit 3 of 0x0F with 2 bytes queued → `o_txd` = 1 asynchronously and `o_count` = 0. After release no further frames appear.
